// File: rtl/tuart_pkg.sv
// Shared types and sizing helpers for the SUMP UART command receiver.
package tuart_pkg;

  // Bit-level receive FSM states.
  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_e;

  // Command assembler states: expecting an opcode, or collecting arguments.
  typedef enum logic {
    ASM_OPC,
    ASM_ARG
  } asm_state_e;

  // Number of bits needed to hold values 0..max_val (at least 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Index of the opcode bit that marks a long command.
  function automatic int opc_long_bit(input int word_bits);
    return word_bits - 1;
  endfunction

endpackage

// File: rtl/tuart_rx_byte.sv
// UART frame receiver: rx synchroniser, start/data/stop bit FSM, divisor counter.
// word_stb_o / ferr_stb_o are asserted during the stop-sample cycle itself so the
// assembler can register its strobes exactly one cycle later.
module tuart_rx_byte
  import tuart_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int DIV_BITS  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic [DIV_BITS-1:0]  div_i,
  output logic [WORD_BITS-1:0] word_o,
  output logic                 word_stb_o,
  output logic                 ferr_stb_o,
  output logic                 busy_o
);

  localparam int                  KW      = cnt_width(WORD_BITS - 1);
  localparam logic [KW-1:0]       K_LAST  = KW'(WORD_BITS - 1);
  localparam logic [DIV_BITS-1:0] DIV_MIN = DIV_BITS'(2);
  localparam logic [DIV_BITS-1:0] ONE     = DIV_BITS'(1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  bit_state_e           state_q, state_d;
  logic [DIV_BITS-1:0]  cnt_q, cnt_d;
  logic [DIV_BITS-1:0]  div_q, div_d;
  logic [DIV_BITS-1:0]  div_eff;
  logic [KW-1:0]        bit_q, bit_d;
  logic [WORD_BITS-1:0] sh_q, sh_d;

  assign rx_s    = sync_q[1];
  assign div_eff = (div_i < DIV_MIN) ? DIV_MIN : div_i;
  assign word_o  = sh_q;
  assign busy_o  = (state_q != BIT_IDLE);

  // Two-flop synchroniser on the asynchronous rx pin, preset to the idle level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignment makes every flop sample the pre-edge value,
      // so sync_q[1] really is two stages behind rx_i.
      sync_q <= {sync_q[0], rx_i};
    end
  end

  // Bit FSM state, divisor counter and shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BIT_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_MIN;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state logic; a sample point is reached when the down-counter hits zero.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = (cnt_q != '0) ? cnt_q - ONE : cnt_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    word_stb_o = 1'b0;
    ferr_stb_o = 1'b0;
    case (state_q)
      BIT_IDLE: begin
        if (!rx_s) begin
          // Divisor is frozen here; the first sample falls half a bit later.
          div_d   = div_eff;
          cnt_d   = (div_eff >> 1) - ONE;
          state_d = BIT_START;
        end
      end
      BIT_START: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            state_d = BIT_IDLE;  // glitch: line went back high
          end else begin
            cnt_d   = div_q - ONE;
            bit_d   = '0;
            state_d = BIT_DATA;
          end
        end
      end
      BIT_DATA: begin
        if (cnt_q == '0) begin
          sh_d  = {rx_s, sh_q[WORD_BITS-1:1]};
          cnt_d = div_q - ONE;
          if (bit_q == K_LAST) state_d = BIT_STOP;
          else                 bit_d   = bit_q + KW'(1);
        end
      end
      BIT_STOP: begin
        if (cnt_q == '0) begin
          state_d = BIT_IDLE;
          if (rx_s) word_stb_o = 1'b1;
          else      ferr_stb_o = 1'b1;
        end
      end
      default: state_d = BIT_IDLE;
    endcase
  end

endmodule

// File: rtl/tuart_rx_sump.sv
// SUMP command receiver: assembles short/long commands from UART words, reports
// framing errors and drops a partial long command after an idle timeout.
module tuart_rx_sump
  import tuart_pkg::*;
#(
  parameter int WORD_BITS   = 8,
  parameter int CMD_WORDS   = 4,
  parameter int DIV_BITS    = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rx_i,
  input  logic [DIV_BITS-1:0]            div_i,
  output logic [WORD_BITS-1:0]           opc_o,
  output logic [WORD_BITS*CMD_WORDS-1:0] cmd_o,
  output logic                           long_o,
  output logic                           stb_o,
  output logic                           ferr_o,
  output logic                           busy_o
);

  localparam int            NW       = cnt_width(CMD_WORDS);
  localparam int            TW       = cnt_width(TIMEOUT_CYC);
  localparam int            LONG_BIT = opc_long_bit(WORD_BITS);
  localparam int            CMD_W    = WORD_BITS * CMD_WORDS;
  localparam logic [NW-1:0] N_LAST   = NW'(CMD_WORDS);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYC - 1);

  logic [WORD_BITS-1:0] word;
  logic                 word_stb, ferr_stb, byte_busy;

  asm_state_e           asm_q, asm_d;
  logic [NW-1:0]        n_q, n_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [WORD_BITS-1:0] opc_hold_q, opc_hold_d;
  logic [CMD_W-1:0]     args_q, args_d, args_tmp;
  logic [WORD_BITS-1:0] opc_d;
  logic [CMD_W-1:0]     cmd_d;
  logic                 long_d, stb_d, ferr_d;

  tuart_rx_byte #(
    .WORD_BITS (WORD_BITS),
    .DIV_BITS  (DIV_BITS)
  ) u_byte (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .div_i      (div_i),
    .word_o     (word),
    .word_stb_o (word_stb),
    .ferr_stb_o (ferr_stb),
    .busy_o     (byte_busy)
  );

  assign busy_o = byte_busy | (n_q != '0);

  // Assembler state, timeout counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      asm_q      <= ASM_OPC;
      n_q        <= '0;
      tcnt_q     <= '0;
      opc_hold_q <= '0;
      args_q     <= '0;
      opc_o      <= '0;
      cmd_o      <= '0;
      long_o     <= 1'b0;
      stb_o      <= 1'b0;
      ferr_o     <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      n_q        <= n_d;
      tcnt_q     <= tcnt_d;
      opc_hold_q <= opc_hold_d;
      args_q     <= args_d;
      opc_o      <= opc_d;
      cmd_o      <= cmd_d;
      long_o     <= long_d;
      stb_o      <= stb_d;
      ferr_o     <= ferr_d;
    end
  end

  // Command assembly: framing error first, then valid words, then idle timeout.
  always_comb begin
    asm_d      = asm_q;
    n_d        = n_q;
    tcnt_d     = tcnt_q;
    opc_hold_d = opc_hold_q;
    args_d     = args_q;
    opc_d      = opc_o;
    cmd_d      = cmd_o;
    long_d     = long_o;
    stb_d      = 1'b0;
    ferr_d     = 1'b0;
    args_tmp   = args_q;
    for (int i = 0; i < CMD_WORDS; i++) begin
      if (n_q == NW'(i + 1)) args_tmp[i*WORD_BITS +: WORD_BITS] = word;
    end

    if (ferr_stb) begin
      ferr_d = 1'b1;
      asm_d  = ASM_OPC;
      n_d    = '0;
      tcnt_d = '0;
    end else if (word_stb) begin
      tcnt_d = '0;
      if (asm_q == ASM_OPC) begin
        if (word[LONG_BIT]) begin
          asm_d      = ASM_ARG;
          n_d        = NW'(1);
          opc_hold_d = word;
          args_d     = '0;
        end else begin
          stb_d  = 1'b1;
          opc_d  = word;
          cmd_d  = '0;
          long_d = 1'b0;
        end
      end else if (n_q == N_LAST) begin
        stb_d  = 1'b1;
        opc_d  = opc_hold_q;
        cmd_d  = args_tmp;
        long_d = 1'b1;
        asm_d  = ASM_OPC;
        n_d    = '0;
      end else begin
        args_d = args_tmp;
        n_d    = n_q + NW'(1);
      end
    end else if (asm_q == ASM_ARG && !byte_busy) begin
      // Only bit-idle cycles count; a frame in flight pauses the timeout.
      if (tcnt_q == T_LAST) begin
        asm_d  = ASM_OPC;
        n_d    = '0;
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tuart_rx_sump.sv
// Self-checking bench: directed scenarios plus randomized command streams,
// compared against a queue-based command model with spec-derived timing.
`timescale 1ns/1ps
module tb_tuart_rx_sump;

  localparam int WB = 8;
  localparam int CW = 4;
  localparam int TO = 200;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rx  = 1'b1;
  logic [15:0]    div = 16'd5;
  logic [WB-1:0]  opc_o;
  logic [WB*CW-1:0] cmd_o;
  logic           long_o, stb_o, ferr_o, busy_o;

  tuart_rx_sump #(
    .WORD_BITS   (WB),
    .CMD_WORDS   (CW),
    .DIV_BITS    (16),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .rx_i   (rx),
    .div_i  (div),
    .opc_o  (opc_o),
    .cmd_o  (cmd_o),
    .long_o (long_o),
    .stb_o  (stb_o),
    .ferr_o (ferr_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [WB-1:0]    opc;
    logic [WB*CW-1:0] cmd;
    logic             lng;
    int               cyc;
  } exp_t;

  exp_t          exp_q[$];
  int            ferr_q[$];
  logic [WB-1:0] part[$];
  logic [WB-1:0]    hold_opc  = '0;
  logic [WB*CW-1:0] hold_cmd  = '0;
  logic             hold_long = 1'b0;

  // Frame driven from cycle ts: 2 cycles of synchroniser lag, half a bit to the
  // start check, WB data bits plus the stop bit, and one cycle to the strobe.
  function automatic int done_cycle(input int ts, input int d);
    return ts + 2 + d / 2 + (WB + 1) * d + 1;
  endfunction

  task automatic model_word(input logic [WB-1:0] w, input bit stop, input int ts, input int d);
    exp_t e;
    int   c;
    c = done_cycle(ts, d);
    if (!stop) begin
      ferr_q.push_back(c);
      part.delete();
    end else if (part.size() == 0 && !w[WB-1]) begin
      e.opc = w; e.cmd = '0; e.lng = 1'b0; e.cyc = c;
      exp_q.push_back(e);
    end else begin
      part.push_back(w);
      if (part.size() == CW + 1) begin
        e.opc = part[0];
        e.cmd = '0;
        for (int i = 1; i <= CW; i++) e.cmd[(i-1)*WB +: WB] = part[i];
        e.lng = 1'b1;
        e.cyc = c;
        exp_q.push_back(e);
        part.delete();
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // All helpers start and end #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [WB-1:0] w, input bit stop, input logic [15:0] dv);
    int d;
    int ts;
    d   = (dv < 16'd2) ? 2 : int'(dv);
    div = dv;
    rx  = 1'b0;
    ts  = cyc;
    model_word(w, stop, ts, d);
    idle(d);
    for (int k = 0; k < WB; k++) begin
      rx = w[k];
      idle(d);
    end
    rx = stop;
    idle(d);
    rx = 1'b1;
  endtask

  // ---------------- output monitor ----------------
  exp_t mon_e;
  int   mon_c;
  always @(negedge clk) begin
    if (!rst) begin
      if (stb_o) begin
        if (exp_q.size() == 0) begin
          check("stb_unexpected", 64'(stb_o), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("stb_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("opc", 64'(opc_o), 64'(mon_e.opc));
          check("cmd", 64'(cmd_o), 64'(mon_e.cmd));
          check("long", 64'(long_o), 64'(mon_e.lng));
          hold_opc  = mon_e.opc;
          hold_cmd  = mon_e.cmd;
          hold_long = mon_e.lng;
        end
      end else begin
        check("outputs_held", 64'({opc_o, cmd_o, long_o}), 64'({hold_opc, hold_cmd, hold_long}));
      end
      if (ferr_o) begin
        if (ferr_q.size() == 0) begin
          check("ferr_unexpected", 64'(ferr_o), 64'd0);
        end else begin
          mon_c = ferr_q.pop_front();
          check("ferr_cycle", 64'(cyc), 64'(mon_c));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [WB-1:0] w;
    logic [15:0]   dv;
    bit            stop;
    bit            is_long;
    int            nwords;

    rst = 1'b1;
    rx  = 1'b1;
    div = 16'd5;
    idle(3);
    check("reset_outputs", 64'({opc_o, cmd_o, long_o, stb_o, ferr_o, busy_o}), 64'd0);
    rst = 1'b0;
    idle(2);

    // 1: short opcode
    send(8'h01, 1'b1, 16'd5);
    idle(10);

    // 2: long command, back-to-back frames
    send(8'h80, 1'b1, 16'd5);
    send(8'h11, 1'b1, 16'd5);
    send(8'h22, 1'b1, 16'd5);
    send(8'h33, 1'b1, 16'd5);
    send(8'h44, 1'b1, 16'd5);
    idle(10);

    // 3: framing error aborts the long command
    send(8'h80, 1'b1, 16'd5);
    send(8'h11, 1'b0, 16'd5);
    idle(20);
    send(8'h02, 1'b1, 16'd5);
    idle(10);

    // 4: one-cycle glitch
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(2);
    @(negedge clk);
    check("glitch_busy_start", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    idle(3);
    check("glitch_busy_after", 64'(busy_o), 64'd0);
    send(8'h03, 1'b1, 16'd5);
    idle(10);

    // 5: inter-word timeout
    send(8'h80, 1'b1, 16'd5);
    send(8'h11, 1'b1, 16'd5);
    idle(5);
    check("partial_busy", 64'(busy_o), 64'd1);
    idle(250);
    part.delete();
    check("timeout_busy", 64'(busy_o), 64'd0);
    send(8'h04, 1'b1, 16'd5);
    idle(10);

    // 6: reset in the middle of a long command
    send(8'h80, 1'b1, 16'd5);
    send(8'h11, 1'b1, 16'd5);
    rx = 1'b0;
    idle(5);
    rx = 1'b0;
    idle(2);
    rst = 1'b1;
    part.delete();
    hold_opc  = '0;
    hold_cmd  = '0;
    hold_long = 1'b0;
    @(negedge clk);
    check("reset_mid_outputs", 64'({opc_o, cmd_o, long_o, stb_o, ferr_o, busy_o}), 64'd0);
    rx = 1'b1;
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    idle(2);
    fork
      send(8'h05, 1'b1, 16'd5);
      begin
        idle(20);
        div = 16'd9;
      end
    join
    send(8'h06, 1'b1, 16'd9);
    idle(5);
    // divisor below 2 runs at 2
    send(8'h85, 1'b1, 16'd1);
    send(8'hA1, 1'b1, 16'd0);
    send(8'hB2, 1'b1, 16'd2);
    send(8'hC3, 1'b1, 16'd3);
    send(8'hD4, 1'b1, 16'd1);
    idle(10);

    // randomized command streams
    for (int it = 0; it < 40; it++) begin
      is_long = ($urandom_range(0, 1) == 1);
      nwords  = is_long ? CW + 1 : 1;
      for (int j = 0; j < nwords; j++) begin
        w = WB'($urandom);
        if (j == 0) w[WB-1] = is_long;
        dv   = 16'($urandom_range(0, 9));
        stop = ($urandom_range(0, 9) != 0);
        send(w, stop, dv);
        if (!stop) begin
          idle(2 * ((dv < 16'd2) ? 2 : int'(dv)) + 4);
          break;
        end
        idle($urandom_range(0, 3));
      end
    end

    idle(40);
    check("pending_stb", 64'(exp_q.size()), 64'd0);
    check("pending_ferr", 64'(ferr_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
